fpu_issue_seq: RTL and testbench

- Operand-issue front end sitting directly upstream of the fpu core (1-bit sign, 6-bit exponent with bias 31, 25-bit mantissa; 2-bit op; 32-bit data_out; 4-bit status_out).
- Accepts operand/op requests over valid/ready into a small FIFO.
- Drives each request onto the fpu inputs and holds them stable for a fixed settle window, because the fpu is multi-cycle and has no done flag.
- Captures data_out/status_out and presents them downstream over valid/ready.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fpu_issue_seq_if.sv | 26 ++
 rtl/fpu_req_fifo.sv | 56 +++++
 rtl/fpu_issue_seq.sv | 114 +++++++++++
 tb/tb_fpu_issue_seq.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu operand-issue front end.
package fpu_pkg;

   localparam int FP_W     = 32;
   localparam int EXP_W    = 6;
   localparam int MAN_W    = 25;
   localparam int EXP_BIAS = 31;

   localparam int OP_W = 2;
   localparam logic [OP_W-1:0] OP_ADD = 2'b00;

   localparam int STATUS_W     = 4;
   localparam int ST_EXACT     = 3;
   localparam int ST_OVERFLOW  = 2;
   localparam int ST_UNDERFLOW = 1;
   localparam int ST_INEXACT   = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RESP = 2'd2
   } seq_state_t;

   typedef struct packed {
      logic [FP_W-1:0] a;
      logic [FP_W-1:0] b;
      logic [OP_W-1:0] op;
   } fpu_req_t;

endpackage

// File: rtl/fpu_issue_seq_if.sv
// Request and result streams of the issue sequencer, both valid/ready.
// master is the upstream/downstream environment, slave is the sequencer.
interface fpu_issue_seq_if;
   import fpu_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [FP_W-1:0]     in_a;
   logic [FP_W-1:0]     in_b;
   logic [OP_W-1:0]     in_op;

   logic                out_valid;
   logic                out_ready;
   logic [FP_W-1:0]     out_data;
   logic [STATUS_W-1:0] out_status;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_data, out_status
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_data, out_status
   );
endinterface

// File: rtl/fpu_req_fifo.sv
// Synchronous request FIFO. Occupancy is held in a registered count so
// full/empty never depend combinationally on push or pop.
module fpu_req_fifo
   import fpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  fpu_req_t               push_data,
   input  logic                   pop,
   output fpu_req_t               pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fpu_req_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fpu_issue_seq.sv
// Operand-issue front end for the multi-cycle fpu core. Requests are
// queued, driven onto the fpu for a fixed settle window, and the result
// is captured and offered downstream.
//
//   state | meaning
//   IDLE  | nothing in flight; issue head of FIFO when non-empty
//   HOLD  | fpu inputs held; count down the settle window
//   RESP  | result captured and offered; wait for out_ready
module fpu_issue_seq
   import fpu_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int HOLD_CYCLES = 100
) (
   input  logic                clk,
   input  logic                reset,
   fpu_issue_seq_if.slave      io,
   output logic [FP_W-1:0]     fpu_a,
   output logic [FP_W-1:0]     fpu_b,
   output logic [OP_W-1:0]     fpu_op,
   input  logic [FP_W-1:0]     fpu_data,
   input  logic [STATUS_W-1:0] fpu_status,
   output logic                busy
);

   localparam int CTR_W = $clog2(HOLD_CYCLES + 1);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   seq_state_t       state;
   logic [CTR_W-1:0] counter;

   fpu_req_t         push_req;
   fpu_req_t         head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             in_push;
   logic             pop;

   assign push_req    = '{a: io.in_a, b: io.in_b, op: io.in_op};
   assign io.in_ready = reset & ~fifo_full;
   assign in_push     = io.in_valid & io.in_ready;

   // Pop only from registered state: IDLE with work, or a RESP handshake.
   assign pop = ~fifo_empty &
                ((state == IDLE) | ((state == RESP) & io.out_ready));

   assign busy = (state != IDLE) | (fifo_count != '0);

   fpu_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (in_push),
      .push_data (push_req),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Issue/hold/respond sequencer; all fpu-facing and result outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         counter       <= '0;
         fpu_a         <= '0;
         fpu_b         <= '0;
         fpu_op        <= '0;
         io.out_valid  <= 1'b0;
         io.out_data   <= '0;
         io.out_status <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  fpu_a   <= head.a;
                  fpu_b   <= head.b;
                  fpu_op  <= head.op;
                  counter <= CTR_W'(HOLD_CYCLES);
                  state   <= HOLD;
               end
            end
            HOLD: begin
               counter <= counter - CTR_W'(1);
               if (counter == CTR_W'(1)) begin
                  io.out_data   <= fpu_data;
                  io.out_status <= fpu_status;
                  io.out_valid  <= 1'b1;
                  state         <= RESP;
               end
            end
            RESP: begin
               if (io.out_ready) begin
                  io.out_valid <= 1'b0;
                  if (pop) begin
                     fpu_a   <= head.a;
                     fpu_b   <= head.b;
                     fpu_op  <= head.op;
                     counter <= CTR_W'(HOLD_CYCLES);
                     state   <= HOLD;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Scoreboard bench for fpu_issue_seq with an integer-add fpu stub.
module tb_fpu_issue_seq;

   localparam int HC    = 4;
   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic [31:0] fpu_a, fpu_b, fpu_data;
   logic [1:0]  fpu_op;
   logic [3:0]  fpu_status;
   logic        busy;

   fpu_issue_seq_if bus ();

   fpu_issue_seq #(
      .FIFO_DEPTH  (DEPTH),
      .HOLD_CYCLES (HC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .io         (bus.slave),
      .fpu_a      (fpu_a),
      .fpu_b      (fpu_b),
      .fpu_op     (fpu_op),
      .fpu_data   (fpu_data),
      .fpu_status (fpu_status),
      .busy       (busy)
   );

   // fpu stub
   assign fpu_data   = fpu_a + fpu_b;
   assign fpu_status = {2'b00, fpu_op};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors     = 0;
   int miscompares = 0;

   logic [35:0] exp_q [$];
   int          hs_log [$];
   int          hs_count = 0;
   int          acc_cyc  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   // Monitor: result scoreboard, result stability in RESP, fpu input stability.
   initial begin
      logic [35:0] prev_word;
      logic        prev_valid;
      logic        prev_hs;
      logic        stable_err;
      logic [65:0] prev_fpu;
      int          since;
      prev_word  = '0;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      stable_err = 1'b0;
      prev_fpu   = '0;
      since      = 100;
      forever begin
         @(negedge clk);
         #1;
         if (!reset) begin
            stable_err = 1'b0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            since      = 100;
            prev_fpu   = {fpu_a, fpu_b, fpu_op};
         end else begin
            if ({fpu_a, fpu_b, fpu_op} != prev_fpu) begin
               check("fpu_hold_stable", 64'(since >= HC), 64'd1);
               since = 0;
            end else begin
               since++;
            end
            prev_fpu = {fpu_a, fpu_b, fpu_op};

            if (bus.out_valid && prev_valid && !prev_hs &&
                {bus.out_data, bus.out_status} != prev_word)
               stable_err = 1'b1;

            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_result", 64'({bus.out_data, bus.out_status}), 64'h0);
                  miscompares += (vectors > 0 && {bus.out_data, bus.out_status} == '0) ? 1 : 0;
               end else begin
                  check("result", 64'({bus.out_data, bus.out_status}), 64'(exp_q.pop_front()));
               end
               check("result_stable", 64'(stable_err), 64'd0);
               stable_err = 1'b0;
               hs_log.push_back(cyc);
               hs_count++;
            end
            prev_hs    = bus.out_valid && bus.out_ready;
            prev_valid = bus.out_valid;
            prev_word  = {bus.out_data, bus.out_status};
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      int i;
      @(negedge clk);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_op    = op;
      bus.in_valid = 1'b1;
      for (i = 0; i < 200; i++) begin
         if (bus.in_ready) break;
         @(negedge clk);
      end
      if (i == 200) begin
         timeout("issue_accept");
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      exp_q.push_back({a + b, 2'b00, op});
      bus.in_valid = 1'b0;
   endtask

   task automatic set_ready(input logic v);
      @(negedge clk);
      bus.out_ready = v;
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #2;
         if (bus.out_valid) return;
      end
      timeout(name);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #2;
         if (!busy) return;
      end
      timeout(name);
   endtask

   task automatic wait_hs(input int n, input string name);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #2;
         if (hs_count >= n) return;
      end
      timeout(name);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_fpu_a"},      64'(fpu_a), 64'h0);
      check({tag, "_fpu_b"},      64'(fpu_b), 64'h0);
      check({tag, "_fpu_op"},     64'(fpu_op), 64'h0);
      check({tag, "_out_valid"},  64'(bus.out_valid), 64'h0);
      check({tag, "_out_data"},   64'(bus.out_data), 64'h0);
      check({tag, "_out_status"}, 64'(bus.out_status), 64'h0);
      check({tag, "_in_ready"},   64'(bus.in_ready), 64'h0);
      check({tag, "_busy"},       64'(busy), 64'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n0;
      reset         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_op     = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

      // 1: single add and latency
      issue(32'h3E00_0000, 32'h3E00_0000, 2'b00);
      wait_valid("s1_valid");
      check("s1_latency", 64'(cyc - acc_cyc), 64'(HC + 1));
      check("s1_data", 64'(bus.out_data), 64'h7C00_0000);
      check("s1_status", 64'(bus.out_status), 64'h0);
      wait_idle("s1_idle");

      // 2: fill with out_ready low, then pulse and stream
      set_ready(1'b0);
      for (int k = 1; k <= 5; k++) issue(32'(k), 32'h10, 2'b01);
      @(negedge clk);
      #1;
      check("s2_full_in_ready", 64'(bus.in_ready), 64'd0);
      check("s2_busy", 64'(busy), 64'd1);
      repeat (10) @(negedge clk);
      #1;
      check("s2_full_hold", 64'(bus.in_ready), 64'd0);
      for (int p = 0; p < 2; p++) begin
         wait_valid("s2_pulse_valid");
         @(negedge clk);
         bus.out_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.out_ready = 1'b0;
      end
      n0 = hs_log.size();
      set_ready(1'b1);
      wait_hs(hs_count + 3, "s2_stream");
      if (hs_log.size() >= n0 + 3) begin
         check("s2_spacing_a", 64'(hs_log[n0+1] - hs_log[n0]), 64'(HC + 1));
         check("s2_spacing_b", 64'(hs_log[n0+2] - hs_log[n0+1]), 64'(HC + 1));
      end
      wait_idle("s2_idle");

      // 3: backpressure in RESP
      set_ready(1'b0);
      issue(32'h100, 32'h200, 2'b10);
      issue(32'h300, 32'h1, 2'b11);
      wait_valid("s3_valid");
      repeat (20) @(negedge clk);
      #1;
      check("s3_hold_fpu_a", 64'(fpu_a), 64'h100);
      check("s3_hold_fpu_b", 64'(fpu_b), 64'h200);
      check("s3_hold_fpu_op", 64'(fpu_op), 64'h2);
      check("s3_hold_valid", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("s3_same_edge_fpu_a", 64'(fpu_a), 64'h300);
      check("s3_same_edge_fpu_op", 64'(fpu_op), 64'h3);
      check("s3_valid_dropped", 64'(bus.out_valid), 64'd0);
      wait_idle("s3_idle");

      // 4: reset mid-HOLD with two entries queued
      issue(32'hA, 32'h1, 2'b00);
      issue(32'hB, 32'h1, 2'b00);
      issue(32'hC, 32'h1, 2'b00);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      exp_q.delete();
      check_reset_outputs("s4");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check("s4_no_result_valid", 64'(bus.out_valid), 64'd0);
      check("s4_no_busy", 64'(busy), 64'd0);
      issue(32'h1234_5678, 32'h1111_1111, 2'b00);
      wait_valid("s4_valid");
      check("s4_latency", 64'(cyc - acc_cyc), 64'(HC + 1));
      check("s4_data", 64'(bus.out_data), 64'h2345_6789);
      wait_idle("s4_idle");

      // 5: push coinciding with the RESP->HOLD pop, FIFO holding 3
      set_ready(1'b0);
      for (int k = 0; k < 4; k++) issue(32'h20 + 32'(k), 32'h1, 2'(k));
      wait_valid("s5_valid");
      @(negedge clk);
      check("s5_pre_in_ready", 64'(bus.in_ready), 64'd1);
      bus.in_a      = 32'h24;
      bus.in_b      = 32'h1;
      bus.in_op     = 2'b00;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back({32'h25, 4'h0});
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      #1;
      check("s5_count3_in_ready", 64'(bus.in_ready), 64'd1);
      issue(32'h25, 32'h1, 2'b01);
      @(negedge clk);
      #1;
      check("s5_count4_in_ready", 64'(bus.in_ready), 64'd0);
      set_ready(1'b1);
      wait_idle("s5_idle");

      // 6: wrap-around, ten requests through the depth-4 FIFO
      n0 = hs_count;
      for (int k = 0; k < 10; k++) issue(32'(k), 32'h0, 2'b00);
      wait_hs(n0 + 10, "s6_results");
      check("s6_busy_at_last_hs", 64'(busy), 64'd1);
      @(negedge clk);
      #2;
      check("s6_busy_fell", 64'(busy), 64'd0);

      repeat (5) @(negedge clk);
      check("all_results_emitted", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
